// File: rtl/if_fetch_queue.sv
// IF/ID fetch queue: a circular buffer that accepts up to PUSH_W fetched entries per cycle
// and presents the POP_W oldest entries to decode. Flush empties it in a single cycle.
module if_fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int PUSH_W = 2,
  parameter int POP_W  = 2,
  parameter int EXC_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [$clog2(PUSH_W+1)-1:0]  push_num_i,
  input  logic [32*PUSH_W-1:0]         push_pc_i,
  input  logic [32*PUSH_W-1:0]         push_instr_i,
  input  logic [EXC_W*PUSH_W-1:0]      push_exc_i,
  output logic                         push_ready_o,
  input  logic [$clog2(POP_W+1)-1:0]   pop_num_i,
  output logic [$clog2(POP_W+1)-1:0]   out_cnt_o,
  output logic [32*POP_W-1:0]          out_pc_o,
  output logic [32*POP_W-1:0]          out_instr_o,
  output logic [EXC_W*POP_W-1:0]       out_exc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PN_W  = $clog2(PUSH_W + 1);
  localparam int ON_W  = $clog2(POP_W + 1);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [EXC_W-1:0] exc;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PN_W-1:0]   push_eff;
  entry_t            rd_e;

  // Readiness looks only at the current occupancy, never at same-cycle pops.
  assign push_ready_o = (count_q <= CNT_W'(DEPTH - PUSH_W));
  assign push_eff     = (push_ready_o && !flush_i) ? push_num_i : '0;
  assign count_o      = count_q;
  assign out_cnt_o    = (count_q >= CNT_W'(POP_W)) ? ON_W'(POP_W) : ON_W'(count_q);

  always_comb begin
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_num_i);
      tail_d  = tail_q + PTR_W'(push_eff);
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_num_i);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; lanes past out_cnt_o are masked to zero instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PUSH_W; k++) begin
        if (PN_W'(k) < push_eff) begin
          mem_q[PTR_W'(tail_q + PTR_W'(k))] <= entry_t'{
            pc:    push_pc_i[32*k +: 32],
            instr: push_instr_i[32*k +: 32],
            exc:   push_exc_i[EXC_W*k +: EXC_W]
          };
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    out_pc_o    = '0;
    out_instr_o = '0;
    out_exc_o   = '0;
    rd_e        = '0;
    for (int k = 0; k < POP_W; k++) begin
      rd_e = mem_q[PTR_W'(head_q + PTR_W'(k))];
      if (ON_W'(k) < out_cnt_o) begin
        out_pc_o[32*k +: 32]          = rd_e.pc;
        out_instr_o[32*k +: 32]       = rd_e.instr;
        out_exc_o[EXC_W*k +: EXC_W]   = rd_e.exc;
      end
    end
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry IF pipeline register, sitting between IF and ID.
- Holds up to DEPTH fetched entries {pc, instr, except}.
- Accepts up to PUSH_W entries per cycle from fetch and presents up to POP_W oldest entries per cycle to decode.
- Decouples I-cache bursts from decode stalls; flush empties it in one cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, must be >= PUSH_W + POP_W.
- PUSH_W, 2, maximum entries written per cycle.
- POP_W, 2, maximum entries read per cycle.
- EXC_W, 8, width of the flattened exception-type field per entry.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- flush_i  in  1  synchronous clear of all entries; no push or pop takes effect that cycle.
- push_num_i  in  $clog2(PUSH_W+1)  number of entries offered this cycle (0..PUSH_W); lane 0 is oldest.
- push_pc_i  in  32*PUSH_W  PC per lane; lane k at bits [32k+31:32k].
- push_instr_i  in  32*PUSH_W  instruction word per lane.
- push_exc_i  in  EXC_W*PUSH_W  exception type per lane.
- push_ready_o  out  1  1 when free slots >= PUSH_W; registered-state function only.
- pop_num_i  in  $clog2(POP_W+1)  number of head entries consumed this cycle; must be <= out_cnt_o.
- out_cnt_o  out  $clog2(POP_W+1)  entries valid on outputs = min(count, POP_W).
- out_pc_o  out  32*POP_W  PC of head+k on lane k.
- out_instr_o  out  32*POP_W  instruction of head+k.
- out_exc_o  out  EXC_W*POP_W  exception type of head+k.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular buffer with head, tail (log2 DEPTH bits) and count registers; pointers wrap modulo DEPTH.
- Reset (rst == 0 at a clock edge):
  - head, tail, count = 0; push_ready_o = 1; out_cnt_o = 0; count_o = 0.
  - All out_* data = 0 (storage is cleared, or outputs are masked to 0 when their lane is invalid).
  - Reset overrides flush, push and pop.
- Flush (flush_i = 1, rst = 1): next cycle head = tail = count = 0. Push and pop in the flush cycle are discarded.
- Push:
  - Effective only if push_ready_o = 1; otherwise push_num_i is ignored and the producer must hold its data.
  - Lanes 0..push_num_i-1 are written to tail, tail+1, ...; tail += push_num_i.
  - Lanes >= push_num_i are ignored.
- Pop:
  - Entries head..head+pop_num_i-1 are retired; head += pop_num_i.
  - pop_num_i > out_cnt_o is illegal; the bench asserts this never happens.
- Simultaneous push and pop: count_next = count + push_eff - pop_num_i.
  - push_ready_o is computed from the current count and does not credit same-cycle pops. This is conservative and guarantees no overflow.
- Latency: a pushed entry appears on the outputs the cycle after the push. There is no same-cycle bypass.
- Outputs are combinational reads of the registered storage at head+k (mod DEPTH), valid for k < out_cnt_o. Invalid lanes drive 0.
- Ordering is strict FIFO. Lane 0 of the output is always the oldest entry.
- Boundaries:
  - Empty: out_cnt_o = 0.
  - count == DEPTH-PUSH_W+1 .. DEPTH: push_ready_o = 0.
  - Wrap: head and tail wrap independently; data crossing index DEPTH-1 -> 0 must remain ordered.
- Invariant: count_o <= DEPTH always; the bench asserts this.

Test Plan:
- Reset, then hold rst = 0 for 2 cycles with push_num = 2 -> count_o = 0, out_cnt_o = 0, push_ready_o = 1, outputs 0.
- Push {0xBFC00000, 0xBFC00004} with instr {0x11, 0x22}, no pop -> next cycle out_cnt_o = 2, out_pc_o lane0 = 0xBFC00000, lane1 = 0xBFC00004, count_o = 2.
- Push 2 per cycle with no pop for 4 cycles (DEPTH = 8) -> count_o reaches 8. push_ready_o = 0 from count 7; a fifth push of PC 0x100 with push_ready_o = 0 is dropped and count_o stays 8.
- Steady state: push 2 and pop 2 per cycle for 20 cycles with incrementing PCs -> count_o constant, every output PC equals the expected sequence across pointer wrap, no gaps or duplicates.
- With count = 5, assert flush_i together with push_num = 2 and pop_num = 1 -> next cycle count_o = 0, out_cnt_o = 0; a subsequent push of PC 0x80000180 appears at lane 0.
- Push entry with exc = 0x04 followed by one with exc = 0, then pop 1 per cycle -> out_exc_o lane0 shows 0x04, then 0x00 on the next cycle; reset asserted mid-stream clears count_o to 0 in one cycle.
